axistream_limit_pkt_len: RTL

//  Downstream stage for the tlast-inserting stream stage. Consumes a tlast-framed AXI-stream and caps packet length at MAX_LEN words.

---
 rtl/axistream_limit_pkt_len.sv | 103 ++++++++++
 1 files changed

// File: rtl/axistream_limit_pkt_len.sv
// rtl/axistream_limit_pkt_len.sv - registered AXI-stream stage that caps packet length at MAX_LEN words
// Words are forwarded one cycle later; a packet reaching MAX_LEN words without tlast gets a forced tlast.
module axistream_limit_pkt_len #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  src_tvalid,
   output logic                  src_tready,
   input  logic [DATA_WIDTH-1:0] src_tdata,
   input  logic                  src_tlast,
   output logic                  dest_tvalid,
   input  logic                  dest_tready,
   output logic [DATA_WIDTH-1:0] dest_tdata,
   output logic                  dest_tlast,
   output logic                  split_pulse,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic [CNT_WIDTH-1:0]  split_count
);

   localparam int WCNT_W = $clog2(MAX_LEN + 1);
   localparam logic [WCNT_W-1:0] LAST_SLOT = WCNT_W'(MAX_LEN - 1);

   logic                  dest_tvalid_q, dest_tvalid_d;
   logic [DATA_WIDTH-1:0] dest_tdata_q, dest_tdata_d;
   logic                  dest_tlast_q, dest_tlast_d;
   logic                  split_pulse_q, split_pulse_d;
   logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
   logic [CNT_WIDTH-1:0]  split_count_q, split_count_d;
   logic [WCNT_W-1:0]     wcnt_q, wcnt_d;

   logic capture;
   logic drain;
   logic last_slot;
   logic force_split;

   assign src_tready  = !rst && (!dest_tvalid_q || dest_tready);
   assign capture     = src_tvalid && src_tready;
   assign drain       = dest_tvalid_q && dest_tready;
   assign last_slot   = (wcnt_q == LAST_SLOT);
   assign force_split = last_slot && !src_tlast;

   always_comb begin
      dest_tvalid_d = dest_tvalid_q;
      dest_tdata_d  = dest_tdata_q;
      dest_tlast_d  = dest_tlast_q;
      split_pulse_d = 1'b0;
      pkt_count_d   = pkt_count_q;
      split_count_d = split_count_q;
      wcnt_d        = wcnt_q;

      // A capture in the same cycle as a drain simply overwrites the buffered word.
      if (capture) begin
         dest_tvalid_d = 1'b1;
         dest_tdata_d  = src_tdata;
         dest_tlast_d  = src_tlast || last_slot;
         wcnt_d        = (src_tlast || last_slot) ? '0 : wcnt_q + WCNT_W'(1);
         if (force_split) begin
            split_pulse_d = 1'b1;
            split_count_d = split_count_q + CNT_WIDTH'(1);
         end
      end else if (drain) begin
         dest_tvalid_d = 1'b0;
      end

      if (drain && dest_tlast_q) begin
         pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dest_tvalid_q <= 1'b0;
         dest_tlast_q  <= 1'b0;
         split_pulse_q <= 1'b0;
         pkt_count_q   <= '0;
         split_count_q <= '0;
         wcnt_q        <= '0;
      end else begin
         dest_tvalid_q <= dest_tvalid_d;
         dest_tlast_q  <= dest_tlast_d;
         split_pulse_q <= split_pulse_d;
         pkt_count_q   <= pkt_count_d;
         split_count_q <= split_count_d;
         wcnt_q        <= wcnt_d;
      end
   end

   // Data needs no reset; it is only meaningful while dest_tvalid is set.
   always_ff @(posedge clk) begin
      dest_tdata_q <= dest_tdata_d;
   end

   assign dest_tvalid = dest_tvalid_q;
   assign dest_tdata  = dest_tdata_q;
   assign dest_tlast  = dest_tlast_q;
   assign split_pulse = split_pulse_q;
   assign pkt_count   = pkt_count_q;
   assign split_count = split_count_q;

endmodule
